// File: rtl/rails_pkg.sv
// rails_pkg: shared state encoding, default sizes and width helper for the rails checker
package rails_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;
    localparam int MAX_N_DEF = 16;
    localparam int DEPTH_DEF = 16;
    function automatic int cnt_w(input int v);
        return $clog2(v + 1);
    endfunction
endpackage

// File: rtl/rails_stack.sv
// rails_stack: bounded LIFO siding holding coach numbers, with synchronous clear
module rails_stack
    import rails_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W = cnt_w(MAX_N_DEF),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [0:DEPTH];
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign top = mem[count - 1'b1];
    // occupancy counter; pop wins over push, clear wins over both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (pop && !empty) count <= count - 1'b1;
        else if (push && !full) count <= count + 1'b1;
    end
    // storage is written at the current count, so the new top sits at count-1
    always_ff @(posedge clk) begin
        if (push && !full && !clear && !(pop && !empty)) mem[count] <= din;
    end
endmodule

// File: rtl/rails_checker.sv
// rails_checker: decides whether a bounded siding can reorder 1..N into the received frame
module rails_checker
    import rails_pkg::*;
#(
    parameter int MAX_N = MAX_N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int W = cnt_w(MAX_N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data,
    output logic         out_valid,
    output logic         result,
    output logic         err
);
    localparam int SW = cnt_w(DEPTH);
    state_t state, state_nxt;
    logic [W-1:0] n, idx, top;
    logic [W-1:0] target [0:MAX_N];
    logic [MAX_N:0] seen;
    logic [W:0] dp, tc;
    logic [SW-1:0] unused_sp;
    logic err_l, acc, hdr_ok, bad, last, clear, push, pop, fin_ok, fin_bad, full, empty;
    assign acc = in_valid && in_ready;
    assign hdr_ok = data != '0 && data <= W'(MAX_N);
    assign bad = data == '0 || data > n || seen[data];
    assign last = idx == n - 1'b1;
    assign clear = state == IDLE && acc;
    rails_stack #(.DEPTH(DEPTH), .W(W)) u_stack (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .push(push),
        .pop(pop),
        .din(tc[W-1:0]),
        .top(top),
        .count(unused_sp),
        .full(full),
        .empty(empty)
    );
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // next state, handshake outputs and the single EVAL action per cycle
    always_comb begin
        state_nxt = state;
        in_ready = state == IDLE || state == LOAD;
        out_valid = state == DONE;
        pop = state == EVAL && !empty && top == target[dp[W-1:0]];
        push = state == EVAL && !pop && tc <= {1'b0, n} && !full;
        fin_ok = pop && dp + 1'b1 == {1'b0, n};
        fin_bad = state == EVAL && !pop && !push;
        case (state)
            IDLE: if (acc) state_nxt = hdr_ok ? LOAD : DONE;
            LOAD: if (acc && last) state_nxt = (err_l || bad) ? DONE : EVAL;
            EVAL: if (fin_ok || fin_bad) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // frame capture, duplicate/range tracking, evaluation indices and verdict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n <= '0;
            idx <= '0;
            dp <= '0;
            tc <= 1;
            seen <= '0;
            err_l <= 1'b0;
            result <= 1'b0;
            err <= 1'b0;
            for (int i = 0; i <= MAX_N; i++) target[i] <= '0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    if (hdr_ok) begin
                        n <= data;
                        idx <= '0;
                        dp <= '0;
                        tc <= 1;
                        seen <= '0;
                        err_l <= 1'b0;
                        for (int i = 0; i <= MAX_N; i++) target[i] <= '0;
                    end else begin
                        err <= 1'b1;
                        result <= 1'b0;
                    end
                end
                LOAD: if (acc) begin
                    target[idx] <= data;
                    seen[data] <= 1'b1;
                    idx <= idx + 1'b1;
                    if (bad) err_l <= 1'b1;
                    if (last && (err_l || bad)) begin
                        err <= 1'b1;
                        result <= 1'b0;
                    end
                end
                EVAL: begin
                    if (pop) dp <= dp + 1'b1;
                    if (push) tc <= tc + 1'b1;
                    if (fin_ok || fin_bad) begin
                        result <= fin_ok;
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
